regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of writeback requesters (0=ALU, 1=MULDIV, 2=MEM).
REQ-002 Parameter DW, 32, data width; AW, 5, register address width.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  NREQ  per-requester write request.
REQ-006 Port req_ready  output  NREQ  per-requester accept; transfer when valid&ready at a rising edge.
REQ-007 Port req_addr  input  NREQ*AW  packed destination addresses, requester i at bits [i*AW +: AW].
REQ-008 Port req_data  input  NREQ*DW  packed write data, same packing.
REQ-009 Port flush  input  1  discard all buffered writes.
REQ-010 Port rf_we, rf_waddr, rf_wdata  output  1/AW/DW  registered write port into the 32x32 register file.
REQ-011 Port busy  output  1  high when any buffer is full or rf_we is high.

Function
REQ-012 Each requester SHALL own a one-entry buffer (addr, data, full flag).
REQ-013 req_ready[i] SHALL be high when buffer i is empty or is granted this cycle, and low during flush.
REQ-014 Grant SHALL go to the oldest full buffer, tracked by an NREQ x NREQ age matrix updated on accept.
REQ-015 Buffers filled on the same edge SHALL be ordered by a round-robin pointer; after each grant, the pointer SHALL move to winner+1 mod NREQ.
REQ-016 Latency: accept at edge N, grant combinational in cycle N+1, rf_we high in cycle N+2 for exactly one cycle.
REQ-017 Throughput SHALL be one write per cycle when any buffer is full.
REQ-018 A granted entry with address 0 SHALL be consumed without asserting rf_we.
REQ-019 Two buffers targeting the same address SHALL be written oldest first, so the younger value persists.
REQ-020 The FSM SHALL have states IDLE (all empty), RUN (at least one full) and FLUSH.
REQ-021 IDLE->RUN on any accept; RUN->IDLE when the last buffer drains with no new accept; any state->FLUSH when flush=1.
REQ-022 FLUSH SHALL last one cycle, clear all full flags and the age matrix, deassert rf_we next cycle, and return to IDLE.
REQ-023 A write already registered on rf_we when flush rises SHALL still complete.
REQ-024 An accept and a grant of the same buffer on one edge SHALL leave the buffer full with the new entry, marked youngest.

Reset
REQ-025 While rst=0: buffers empty, age matrix clear, pointer=0, FSM=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, req_ready=all-ones after release.
REQ-026 Reset asserted mid-operation SHALL drop all buffered and pending writes immediately, with no partial write.

Configuration
REQ-027 Macro RF_WB_BYPASS_EN SHALL add ports byp_raddr1/byp_raddr2 (input AW), byp_hit1/byp_hit2 (output 1) and byp_data1/byp_data2 (output DW).
REQ-028 With the macro defined, byp_hitK SHALL be high combinationally when rf_we=1, rf_waddr=byp_raddrK and rf_waddr!=0, and byp_dataK SHALL equal rf_wdata.
REQ-029 With the macro defined, byp_hitK SHALL be 0 and byp_dataK SHALL be 0 otherwise.
REQ-030 Without the macro, the bypass ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package regfile_pkg SHALL hold the DW/AW constants, the requester index constants (REQ_ALU, REQ_MULDIV, REQ_MEM) and the FSM state encoding.
REQ-032 One sub-module, rr_oldest_pick, SHALL take the full flags, age matrix and pointer and return a one-hot grant; everything else stays in regfile_wb_arbiter.

Verification
REQ-033 Single write: ALU valid at edge 1, addr=5, data=0xDEADBEEF -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 3 only; busy falls after.
REQ-034 Simultaneous writes: all three requesters valid at the same edge, addrs 1/2/3, pointer=0 -> writes in order 1, 2, 3 on three consecutive cycles; pointer ends at 0.
REQ-035 Same-address ordering: MEM accepts addr=8, data=0x11; one cycle later ALU accepts addr=8, data=0x22 -> 0x11 written first, then 0x22.
REQ-036 Zero register: MULDIV writes addr=0, data=0xFFFFFFFF -> req_ready returns high and rf_we stays 0 throughout.
REQ-037 Flush/reset: two buffers full, flush pulsed -> no rf_we for those entries and FSM back in IDLE; repeat with rst=0 mid-RUN -> all outputs 0 asynchronously.
REQ-038 Bypass (RF_WB_BYPASS_EN defined): rf_we to addr 7 with byp_raddr1=7 and byp_raddr2=0 -> byp_hit1=1 with byp_data1=rf_wdata, byp_hit2=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the register-file writeback arbiter.
package regfile_pkg;

    localparam int unsigned RF_DW   = 32;
    localparam int unsigned RF_AW   = 5;
    localparam int unsigned RF_NREQ = 3;

    localparam int unsigned REQ_ALU    = 0;
    localparam int unsigned REQ_MULDIV = 1;
    localparam int unsigned REQ_MEM    = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } wb_state_e;

endpackage

// File: rtl/rr_oldest_pick.sv
// Picks the oldest full buffer; equally old buffers are resolved round-robin from ptr.
module rr_oldest_pick #(
    parameter  int unsigned NREQ = 3,
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]           full,
    input  logic [NREQ-1:0][NREQ-1:0] age,
    input  logic [PW-1:0]             ptr,
    output logic [NREQ-1:0]           grant
);

    logic [NREQ-1:0] elig;
    logic            found;

    always_comb begin
        // age[j][i] set means j holds an entry older than i
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = full[i];
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (j != i && full[j] && age[j][i]) begin
                    elig[i] = 1'b0;
                end
            end
        end

        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && elig[(32'(ptr) + k) % NREQ]) begin
                grant[(32'(ptr) + k) % NREQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: one-entry buffer per requester, oldest-first grant into the register file.
// Define RF_WB_BYPASS_EN to add two read-bypass ports that forward the registered write.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = RF_NREQ,
    parameter int unsigned DW   = RF_DW,
    parameter int unsigned AW   = RF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 flush,
`ifdef RF_WB_BYPASS_EN
    input  logic [AW-1:0]        byp_raddr1,
    input  logic [AW-1:0]        byp_raddr2,
    output logic                 byp_hit1,
    output logic                 byp_hit2,
    output logic [DW-1:0]        byp_data1,
    output logic [DW-1:0]        byp_data2,
`endif
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic                 busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_state_e                 state_q, state_d;
    logic [NREQ-1:0]           full_q, full_d;
    logic [NREQ-1:0][AW-1:0]   addr_q, addr_d;
    logic [NREQ-1:0][DW-1:0]   data_q, data_d;
    logic [NREQ-1:0][NREQ-1:0] age_q, age_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic                      rf_we_q, rf_we_d;
    logic [AW-1:0]             rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]             rf_wdata_q, rf_wdata_d;

    logic [NREQ-1:0] pick_grant, grant, hold, accept;

    rr_oldest_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .full  (full_q),
        .age   (age_q),
        .ptr   (ptr_q),
        .grant (pick_grant)
    );

    // No grant while flushing, so flushed entries never reach the register file
    assign grant     = flush ? '0 : pick_grant;
    assign hold      = full_q & ~grant;
    assign req_ready = (~full_q | grant) & {NREQ{!flush && state_q != StFlush}};
    assign accept    = req_valid & req_ready;

    always_comb begin
        full_d = flush ? '0 : (hold | accept);
        addr_d = addr_q;
        data_d = data_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                addr_d[i] = req_addr[i*AW +: AW];
                data_d[i] = req_data[i*DW +: DW];
            end
        end

        // A surviving entry is older than anything newly accepted; new entries tie each other
        age_d = '0;
        if (!flush) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (i != j) begin
                        age_d[i][j] = hold[i] & (accept[j] | (age_q[i][j] & hold[j]));
                    end
                end
            end
        end

        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
                if (addr_q[i] != '0) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = addr_q[i];
                    rf_wdata_d = data_q[i];
                end
            end
        end

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|accept) state_d = StRun;
            StRun:   if (full_d == '0) state_d = StIdle;
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StFlush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            full_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            age_q      <= '0;
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            age_q      <= age_d;
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = (|full_q) | rf_we_q;

`ifdef RF_WB_BYPASS_EN
    always_comb begin
        byp_hit1  = rf_we_q && (rf_waddr_q == byp_raddr1) && (rf_waddr_q != '0);
        byp_hit2  = rf_we_q && (rf_waddr_q == byp_raddr2) && (rf_waddr_q != '0);
        byp_data1 = byp_hit1 ? rf_wdata_q : '0;
        byp_data2 = byp_hit2 ? rf_wdata_q : '0;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: timestamp-based reference model plus directed literal checks.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic                flush;
    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic                busy;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0]       byp_raddr1, byp_raddr2;
    logic                byp_hit1, byp_hit2;
    logic [DW-1:0]       byp_data1, byp_data2;
`endif

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .flush      (flush),
`ifdef RF_WB_BYPASS_EN
        .byp_raddr1 (byp_raddr1),
        .byp_raddr2 (byp_raddr2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2),
`endif
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: each buffer remembers the edge number it was filled on
    bit          m_full  [NREQ];
    int          m_stamp [NREQ];
    logic [AW-1:0] m_addr [NREQ];
    logic [DW-1:0] m_data [NREQ];
    int          m_ptr;
    bit          m_fl;
    bit          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int          m_edge;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_full[i] = 0; m_stamp[i] = 0; m_addr[i] = '0; m_data[i] = '0;
        end
        m_ptr = 0; m_fl = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_edge = 0;
    endtask

    function automatic int m_winner();
        int best;
        int idx;
        best = -1;
        if (flush) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (m_full[idx] && (best < 0 || m_stamp[idx] < m_stamp[best])) best = idx;
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] m_ready();
        logic [NREQ-1:0] r;
        int w;
        w = m_winner();
        for (int i = 0; i < NREQ; i++) r[i] = !flush && !m_fl && (!m_full[i] || w == i);
        return r;
    endfunction

    task automatic model_edge();
        int w;
        logic [NREQ-1:0] rdy;
        w   = m_winner();
        rdy = m_ready();
        m_edge++;
        m_we = 0;
        if (w >= 0) begin
            if (m_addr[w] != 0) begin
                m_we = 1; m_waddr = m_addr[w]; m_wdata = m_data[w];
            end
            m_full[w] = 0;
            m_ptr = (w + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && rdy[i]) begin
                m_full[i]  = 1;
                m_stamp[i] = m_edge;
                m_addr[i]  = req_addr[i*AW +: AW];
                m_data[i]  = req_data[i*DW +: DW];
            end
        end
        if (flush) for (int i = 0; i < NREQ; i++) m_full[i] = 0;
        m_fl = flush;
    endtask

    task automatic compare_outputs();
        bit any_full;
        any_full = 0;
        for (int i = 0; i < NREQ; i++) any_full |= m_full[i];
        check("req_ready", 32'(req_ready), 32'(m_ready()));
        check("busy", 32'(busy), 32'(any_full || m_we));
        check("rf_we", 32'(rf_we), 32'(m_we));
        if (m_we) begin
            check("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            check("rf_wdata", rf_wdata, m_wdata);
        end
`ifdef RF_WB_BYPASS_EN
        begin
            bit h1, h2;
            h1 = m_we && m_waddr == byp_raddr1 && m_waddr != 0;
            h2 = m_we && m_waddr == byp_raddr2 && m_waddr != 0;
            check("byp_hit1", 32'(byp_hit1), 32'(h1));
            check("byp_hit2", 32'(byp_hit2), 32'(h2));
            check("byp_data1", byp_data1, h1 ? m_wdata : 32'h0);
            check("byp_data2", byp_data2, h2 ? m_wdata : 32'h0);
        end
`endif
    endtask

    // Inputs are set at the falling edge; compare, then advance one rising edge
    task automatic tick();
        #1 compare_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
`ifdef RF_WB_BYPASS_EN
        byp_raddr1 = '0; byp_raddr2 = '0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset rf_we", 32'(rf_we), 32'd0);
        check("reset rf_waddr", 32'(rf_waddr), 32'd0);
        check("reset rf_wdata", rf_wdata, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("ready after release", 32'(req_ready), 32'h7);
        @(negedge clk);

        // Three simultaneous writes with pointer at 0
        drive(REQ_ALU, 5'd1, 32'hA1); drive(REQ_MULDIV, 5'd2, 32'hA2); drive(REQ_MEM, 5'd3, 32'hA3);
        tick();
        req_valid = '0;
        check("sim latency rf_we", 32'(rf_we), 32'd0);
        check("sim latency busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("sim order rf_we", 32'(rf_we), 32'd1);
            check("sim order waddr", 32'(rf_waddr), 32'(k));
            check("sim order wdata", rf_wdata, 32'hA0 + 32'(k));
        end
        tick();
        check("sim drained", 32'(rf_we), 32'd0);

        // Single write
        drive(REQ_ALU, 5'd5, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        check("single cycle2 rf_we", 32'(rf_we), 32'd0);
        tick();
        check("single rf_we", 32'(rf_we), 32'd1);
        check("single waddr", 32'(rf_waddr), 32'd5);
        check("single wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        check("single done rf_we", 32'(rf_we), 32'd0);
        check("single done busy", 32'(busy), 32'd0);

        // Same address, MEM first then ALU
        drive(REQ_MEM, 5'd8, 32'h11);
        tick();
        req_valid = '0;
        drive(REQ_ALU, 5'd8, 32'h22);
        tick();
        req_valid = '0;
        check("same-addr first", rf_wdata, 32'h11);
        tick();
        check("same-addr second we", 32'(rf_we), 32'd1);
        check("same-addr second", rf_wdata, 32'h22);
        tick();

        // Zero register
        drive(REQ_MULDIV, 5'd0, 32'hFFFFFFFF);
        tick();
        req_valid = '0;
        repeat (3) begin
            check("zero-reg rf_we", 32'(rf_we), 32'd0);
            tick();
        end
        check("zero-reg ready", 32'(req_ready), 32'h7);

        // Flush with two buffers full
        drive(REQ_ALU, 5'd9, 32'h99); drive(REQ_MULDIV, 5'd10, 32'hAA);
        tick();
        req_valid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush rf_we", 32'(rf_we), 32'd0);
        tick();
        check("flush rf_we 2", 32'(rf_we), 32'd0);
        check("flush busy", 32'(busy), 32'd0);
        tick();
        check("flush idle ready", 32'(req_ready), 32'h7);

        // Asynchronous reset mid-run
        drive(REQ_ALU, 5'd4, 32'h44); drive(REQ_MULDIV, 5'd5, 32'h55); drive(REQ_MEM, 5'd6, 32'h66);
        tick();
        req_valid = '0;
        tick();
        check("pre-reset rf_we", 32'(rf_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async rst rf_we", 32'(rf_we), 32'd0);
        check("async rst waddr", 32'(rf_waddr), 32'd0);
        check("async rst wdata", rf_wdata, 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post-reset rf_we", 32'(rf_we), 32'd0);

`ifdef RF_WB_BYPASS_EN
        drive(REQ_ALU, 5'd7, 32'h77);
        tick();
        req_valid = '0;
        tick();
        byp_raddr1 = 5'd7; byp_raddr2 = 5'd0;
        #1;
        check("byp hit1", 32'(byp_hit1), 32'd1);
        check("byp data1", byp_data1, 32'h77);
        check("byp hit2", 32'(byp_hit2), 32'd0);
        check("byp data2", byp_data2, 32'd0);
        tick();
`endif

        // Randomized traffic with occasional flushes
        repeat (3000) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 6);
                req_addr[i*AW +: AW] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
                req_data[i*DW +: DW] = $urandom;
            end
            flush = ($urandom_range(0, 39) == 0);
`ifdef RF_WB_BYPASS_EN
            byp_raddr1 = 5'($urandom_range(0, 12));
            byp_raddr2 = 5'($urandom_range(0, 12));
`endif
            tick();
        end
        req_valid = '0;
        flush = 1'b0;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
